// File: rtl/mmu_tlb_lookup.sv
// mmu_tlb_lookup: multi-port fully-associative TLB with DMW bypass, CSR writes and INVTLB sweep
// Ports: Clk/Rest (async active-high); Lk* per-port lookup requests, Rs* registered results
// (1-cycle latency); Wr* whole-entry write; Inv* INVTLB request and busy/done handshake.
// Optional MMU_PERF_CNT_EN adds HitCnt/MissCnt lookup counters.
module mmu_tlb_lookup #(
  parameter int NUM_PORTS   = 2,
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                       Clk,
  input  logic                       Rest,
  input  logic [9:0]                 Asid,
  input  logic [NUM_PORTS-1:0]       LkValid,
  input  logic [32*NUM_PORTS-1:0]    LkVa,
  input  logic [NUM_PORTS-1:0]       LkDmwHit,
  input  logic [3*NUM_PORTS-1:0]     LkDmwPseg,
  input  logic [2*NUM_PORTS-1:0]     LkDmwMat,
  output logic [NUM_PORTS-1:0]       RsValid,
  output logic [NUM_PORTS-1:0]       RsFound,
  output logic [32*NUM_PORTS-1:0]    RsPa,
  output logic [NUM_PORTS-1:0]       RsV,
  output logic [NUM_PORTS-1:0]       RsD,
  output logic [2*NUM_PORTS-1:0]     RsMat,
  output logic [2*NUM_PORTS-1:0]     RsPlv,
  output logic [IDX_W*NUM_PORTS-1:0] RsIndex,
  input  logic                       WrEn,
  input  logic [IDX_W-1:0]           WrIndex,
  input  logic                       WrE,
  input  logic                       WrG,
  input  logic [5:0]                 WrPs,
  input  logic [9:0]                 WrAsid,
  input  logic [18:0]                WrVppn,
  input  logic [19:0]                WrPpn0,
  input  logic [19:0]                WrPpn1,
  input  logic [5:0]                 WrAttr0,
  input  logic [5:0]                 WrAttr1,
  input  logic                       InvReq,
  input  logic [4:0]                 InvOp,
  input  logic [9:0]                 InvAsid,
  input  logic [31:0]                InvVa,
  output logic                       InvBusy,
  output logic                       InvDone
`ifdef MMU_PERF_CNT_EN
  ,
  output logic [31:0]                HitCnt,
  output logic [31:0]                MissCnt
`endif
);
  typedef struct packed {
    logic e, g, ps21;
    logic [9:0] asid;
    logic [18:0] vppn;
    logic [19:0] ppn0, ppn1;
    logic [5:0] attr0, attr1;
  } entry_t;
  typedef struct packed {
    logic f;
    logic [31:0] pa;
    logic v, d;
    logic [1:0] mat, plv;
    logic [IDX_W-1:0] idx;
  } res_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_ENTRIES - 1);
  entry_t tlb [TLB_ENTRIES];
  entry_t wr_ent;
  res_t r [NUM_PORTS];
  state_t state, nstate;
  logic [IDX_W-1:0] ptr, nptr;
  logic [4:0] inv_op;
  logic [9:0] inv_asid;
  logic [18:0] inv_vpn;
  logic am, vm, sel, clr;
  logic unused;
  assign unused = &{1'b0, InvVa[12:0]};
  // vpn is VA[31:13]; a 2MB page ignores the low 9 bits of both sides
  function automatic logic va_hit(input logic ps21, input logic [18:0] vppn, input logic [18:0] vpn);
    return ps21 ? vpn[18:9] == vppn[18:9] : vpn == vppn;
  endfunction
  function automatic res_t look(input logic [31:0] va, input logic dmw, input logic [2:0] pseg,
                                input logic [1:0] dmat);
    logic hit;
    logic [IDX_W-1:0] idx;
    logic odd;
    logic [19:0] ppn;
    logic [5:0] a;
    hit = 1'b0;
    idx = '0;
    // descending scan so the lowest matching index is the one left standing
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (tlb[i].e && (tlb[i].g || tlb[i].asid == Asid) && va_hit(tlb[i].ps21, tlb[i].vppn, va[31:13])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    odd = tlb[idx].ps21 ? va[21] : va[12];
    ppn = odd ? tlb[idx].ppn1 : tlb[idx].ppn0;
    a = odd ? tlb[idx].attr1 : tlb[idx].attr0;
    if (dmw) return '{f: 1'b1, pa: {pseg, va[28:0]}, v: 1'b1, d: 1'b1, mat: dmat, plv: 2'b0, idx: '0};
    if (!hit) return '0;
    return '{f: 1'b1, pa: tlb[idx].ps21 ? {ppn[19:9], va[20:0]} : {ppn, va[11:0]},
             v: a[5], d: a[4], mat: a[3:2], plv: a[1:0], idx: idx};
  endfunction
  assign wr_ent = {WrE, WrG, WrPs == 6'd21, WrAsid, WrVppn, WrPpn0, WrPpn1, WrAttr0, WrAttr1};
  always_comb
    for (int p = 0; p < NUM_PORTS; p++)
      r[p] = LkValid[p] ? look(LkVa[32*p +: 32], LkDmwHit[p], LkDmwPseg[3*p +: 3], LkDmwMat[2*p +: 2]) : '0;
  always_ff @(posedge Clk or posedge Rest)
    if (Rest) {RsValid, RsFound, RsPa, RsV, RsD, RsMat, RsPlv, RsIndex} <= '0;
    else
      for (int p = 0; p < NUM_PORTS; p++) begin
        RsValid[p] <= LkValid[p];
        RsFound[p] <= r[p].f;
        RsPa[32*p +: 32] <= r[p].pa;
        RsV[p] <= r[p].v;
        RsD[p] <= r[p].d;
        RsMat[2*p +: 2] <= r[p].mat;
        RsPlv[2*p +: 2] <= r[p].plv;
        RsIndex[IDX_W*p +: IDX_W] <= r[p].idx;
      end
  assign am = tlb[ptr].asid == inv_asid;
  assign vm = va_hit(tlb[ptr].ps21, tlb[ptr].vppn, inv_vpn);
  assign sel = inv_op <= 5'd1 ? 1'b1 :
               inv_op == 5'd2 ? tlb[ptr].g :
               inv_op == 5'd3 ? !tlb[ptr].g :
               inv_op == 5'd4 ? !tlb[ptr].g && am :
               inv_op == 5'd5 ? !tlb[ptr].g && am && vm :
               (tlb[ptr].g || am) && vm;
  // a concurrent write owns the cycle; the sweep holds ptr and re-evaluates it next cycle
  assign clr = state == SWEEP && !WrEn && sel;
  always_ff @(posedge Clk or posedge Rest)
    if (Rest) for (int i = 0; i < TLB_ENTRIES; i++) tlb[i] <= '0;
    else if (WrEn) tlb[WrIndex] <= wr_ent;
    else if (clr) tlb[ptr].e <= 1'b0;
  always_comb begin
    nstate = state;
    nptr = ptr;
    if (state == IDLE && InvReq) begin
      nstate = InvOp <= 5'd6 ? SWEEP : DONE;
      nptr = '0;
    end else if (state == SWEEP && !WrEn) begin
      nptr = ptr + 1'b1;
      nstate = ptr == LAST ? DONE : SWEEP;
    end else if (state == DONE) nstate = IDLE;
  end
  always_ff @(posedge Clk or posedge Rest)
    if (Rest) begin
      state <= IDLE;
      ptr <= '0;
      {inv_op, inv_asid, inv_vpn} <= '0;
    end else begin
      state <= nstate;
      ptr <= nptr;
      if (state == IDLE && InvReq) {inv_op, inv_asid, inv_vpn} <= {InvOp, InvAsid, InvVa[31:13]};
    end
  assign InvBusy = state != IDLE;
  assign InvDone = state == DONE;
`ifdef MMU_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Rest)
    if (Rest) {HitCnt, MissCnt} <= '0;
    else begin
      HitCnt <= HitCnt + 32'($countones(RsValid & RsFound));
      MissCnt <= MissCnt + 32'($countones(RsValid & ~RsFound));
    end
`endif
endmodule
